// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and SHA-256 bit functions.
package sha256_pkg;

  localparam int unsigned MAX_BYTES = 55;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PAD   = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [WORD_W-1:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_output_handler.sv
// Serialises a 256-bit digest into sixteen 16-bit halfwords, MSB first.
module sha256_output_handler (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] digest,
  output logic [15:0]  hashed_data,
  output logic         done
);

  logic         read_enable;
  logic [3:0]   index;
  logic [239:0] pending;

  // First halfword is registered on the start edge; the rest shift out behind it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hashed_data <= '0;
      read_enable <= 1'b0;
      done        <= 1'b0;
      index       <= '0;
      pending     <= '0;
    end else if (start) begin
      hashed_data <= digest[255:240];
      pending     <= digest[239:0];
      read_enable <= 1'b1;
      done        <= 1'b0;
      index       <= '0;
    end else if (read_enable) begin
      if (index == 4'd15) begin
        hashed_data <= '0;
        read_enable <= 1'b0;
        done        <= 1'b0;
        index       <= '0;
      end else begin
        hashed_data <= pending[239:224];
        pending     <= {pending[223:0], 16'h0000};
        done        <= (index == 4'd14);
        index       <= index + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sha256_stream_hasher.sv
// Byte-serial single-block SHA-256: capture, pad, 64 rounds, then stream the digest.
module sha256_stream_hasher
  import sha256_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_enable,
  input  logic        input_complete,
  input  logic [7:0]  input_data,
  output logic [15:0] hashed_data
);

  state_t        state;
  state_t        state_nxt;
  logic [5:0]    count;
  logic [7:0]    msg_mem [MAX_BYTES];
  logic [31:0]   h_reg [8];
  logic [31:0]   v [8];
  logic [5:0]    round_idx;
  logic [511:0]  w_win;
  logic [511:0]  block_c;
  logic [255:0]  digest_c;
  logic [31:0]   w0_c;
  logic [31:0]   w_new_c;
  logic [31:0]   t1_c;
  logic [31:0]   t2_c;
  logic          start_c;
  logic          out_done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (input_complete) state_nxt = PAD;
      PAD:     state_nxt = ROUND;
      ROUND:   if (round_idx == 6'd63) state_nxt = FINAL;
      FINAL:   state_nxt = OUT;
      OUT:     if (out_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Padded block: message bytes, 0x80 marker, zeros, 64-bit big-endian bit length.
  always_comb begin
    block_c = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++)
      if (6'(i) < count) block_c[511 - 8*i -: 8] = msg_mem[i];
    for (int i = 0; i <= int'(MAX_BYTES); i++)
      if (6'(i) == count) block_c[511 - 8*i -: 8] = 8'h80;
    block_c[63:0] = 64'({count, 3'b000});
  end

  always_comb begin
    w0_c    = w_win[511:480];
    w_new_c = small_sigma1(w_win[63:32]) + w_win[223:192] + small_sigma0(w_win[479:448]) + w0_c;
    t1_c    = v[7] + big_sigma1(v[4]) + ch(v[4], v[5], v[6]) + K[round_idx] + w0_c;
    t2_c    = big_sigma0(v[0]) + maj(v[0], v[1], v[2]);
    start_c = (state == FINAL);
    digest_c = '0;
    for (int i = 0; i < 8; i++)
      digest_c[255 - 32*i -: 32] = h_reg[i] + v[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      round_idx <= '0;
      w_win     <= '0;
      for (int i = 0; i < int'(MAX_BYTES); i++) msg_mem[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        h_reg[i] <= H_INIT[i];
        v[i]     <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (load_enable && !input_complete && count < 6'(MAX_BYTES)) begin
            msg_mem[count] <= input_data;
            count          <= count + 6'd1;
          end
        end
        PAD: begin
          for (int i = 0; i < 8; i++) v[i] <= h_reg[i];
          w_win     <= block_c;
          round_idx <= '0;
        end
        ROUND: begin
          v[0] <= t1_c + t2_c;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1_c;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          w_win     <= {w_win[479:0], w_new_c};
          round_idx <= round_idx + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= digest_c[255 - 32*i -: 32];
        end
        OUT: begin
          if (out_done) begin
            count <= '0;
            for (int i = 0; i < 8; i++) h_reg[i] <= H_INIT[i];
          end
        end
        default: ;
      endcase
    end
  end

  sha256_output_handler output_handler (
    .clock       (clock),
    .reset       (reset),
    .start       (start_c),
    .digest      (digest_c),
    .hashed_data (hashed_data),
    .done        (out_done)
  );

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Randomised bench for sha256_stream_hasher against an array-based SHA-256 model.
module tb_sha256_stream_hasher;

  logic        clock;
  logic        reset;
  logic        load_enable;
  logic        input_complete;
  logic [7:0]  input_data;
  logic [15:0] hashed_data;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] HT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  sha256_stream_hasher dut (
    .clock          (clock),
    .reset          (reset),
    .load_enable    (load_enable),
    .input_complete (input_complete),
    .input_data     (input_data),
    .hashed_data    (hashed_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // Straight-line FIPS 180-4 on one block; messages longer than 55 bytes are truncated.
  function automatic logic [255:0] sha_ref(input logic [7:0] m [64], input int n);
    logic [7:0]   blk [64];
    logic [31:0]  w [64];
    logic [31:0]  wv [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [63:0]  bits;
    logic [255:0] r;
    int len;
    len = (n > 55) ? 55 : n;
    for (int i = 0; i < 64; i++) blk[i] = (i < len) ? m[i] : 8'h00;
    blk[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) blk[56 + i] = bits[63 - 8*i -: 8];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = {blk[4*t], blk[4*t+1], blk[4*t+2], blk[4*t+3]};
      else begin
        s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
    end
    for (int i = 0; i < 8; i++) wv[i] = HT[i];
    for (int t = 0; t < 64; t++) begin
      s1 = rr(wv[4], 6) ^ rr(wv[4], 11) ^ rr(wv[4], 25);
      t1 = wv[7] + s1 + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + KT[t] + w[t];
      s0 = rr(wv[0], 2) ^ rr(wv[0], 13) ^ rr(wv[0], 22);
      t2 = s0 + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      for (int i = 7; i > 0; i--) wv[i] = wv[i-1];
      wv[4] = wv[4] + t1;
      wv[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = HT[i] + wv[i];
    return r;
  endfunction

  task automatic load_bytes(input logic [7:0] m [64], input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_enable = 1'b0;
        tick();
      end
      load_enable = 1'b1;
      input_data  = m[i];
      tick();
    end
    // Completion cycle may carry a stray byte strobe; it must not be captured.
    load_enable    = 1'($urandom_range(0, 1));
    input_data     = 8'($urandom);
    input_complete = 1'b1;
    tick();
    load_enable    = 1'b0;
    input_complete = 1'b0;
  endtask

  task automatic run_msg(input logic [7:0] m [64], input int n, input bit noisy,
                         input bit has_known, input logic [255:0] known, input string tag);
    logic [255:0] got;
    int first_edge, done_edge, re_cnt, done_cnt, zero_viol;
    got = '0; first_edge = -1; done_edge = -1; re_cnt = 0; done_cnt = 0; zero_viol = 0;
    load_bytes(m, n);
    for (int e = 1; e <= 90; e++) begin
      if (noisy && e <= 81) begin
        load_enable    = 1'($urandom_range(0, 1));
        input_complete = 1'($urandom_range(0, 1));
        input_data     = 8'($urandom);
      end else begin
        load_enable    = 1'b0;
        input_complete = 1'b0;
      end
      tick();
      if (dut.output_handler.read_enable) begin
        if (first_edge < 0) first_edge = e;
        got = {got[239:0], hashed_data};
        re_cnt++;
      end else if (hashed_data != 16'h0) zero_viol++;
      if (dut.output_handler.done) begin
        done_cnt++;
        done_edge = e;
      end
    end
    load_enable = 1'b0;
    input_complete = 1'b0;
    check_eq({tag, "_first_edge"}, 256'(first_edge), 256'(66));
    check_eq({tag, "_done_edge"}, 256'(done_edge), 256'(81));
    check_eq({tag, "_re_cycles"}, 256'(re_cnt), 256'(16));
    check_eq({tag, "_done_cycles"}, 256'(done_cnt), 256'(1));
    check_eq({tag, "_zero_outside"}, 256'(zero_viol), 256'(0));
    check_eq({tag, "_digest_model"}, got, sha_ref(m, n));
    if (has_known) check_eq({tag, "_digest_known"}, got, known);
  endtask

  // Reset after `depth` edges past input_complete; outputs must clear and stay quiet.
  task automatic reset_abort(input logic [7:0] m [64], input int n, input int depth, input string tag);
    int re_seen;
    re_seen = 0;
    load_bytes(m, n);
    repeat (depth) tick();
    reset = 1'b0;
    #1;
    check_eq({tag, "_re"}, 256'(dut.output_handler.read_enable), 256'(0));
    check_eq({tag, "_done"}, 256'(dut.output_handler.done), 256'(0));
    check_eq({tag, "_data"}, 256'(hashed_data), 256'(0));
    repeat (3) tick();
    reset = 1'b1;
    for (int e = 0; e < 90; e++) begin
      tick();
      if (dut.output_handler.read_enable || hashed_data != 16'h0) re_seen++;
    end
    check_eq({tag, "_quiet_after"}, 256'(re_seen), 256'(0));
  endtask

  logic [7:0] msg [64];
  logic [7:0] abc [64];

  initial begin
    reset = 1'b0;
    load_enable = 1'b0;
    input_complete = 1'b0;
    input_data = 8'h00;
    repeat (3) tick();
    check_eq("rst_re", 256'(dut.output_handler.read_enable), 256'(0));
    check_eq("rst_done", 256'(dut.output_handler.done), 256'(0));
    check_eq("rst_data", 256'(hashed_data), 256'(0));
    reset = 1'b1;

    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    run_msg(msg, 0, 1'b0, 1'b1,
            256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, "empty");

    for (int i = 0; i < 64; i++) abc[i] = 8'h00;
    abc[0] = 8'h61; abc[1] = 8'h62; abc[2] = 8'h63;
    run_msg(abc, 3, 1'b0, 1'b1,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, "abc");
    run_msg(abc, 3, 1'b1, 1'b1,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, "abc_again");

    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    msg[0] = 8'h43; msg[1] = 8'h53; msg[2] = 8'h45; msg[3] = 8'h33;
    msg[4] = 8'h30; msg[5] = 8'h33; msg[6] = 8'h34; msg[7] = 8'h32;
    run_msg(msg, 8, 1'b0, 1'b1,
            256'h5f0c51e04c279254ff7547291c39356e5102e76214614d38a918730669aef9d0, "cse");

    reset_abort(abc, 3, 20, "rst_round");
    run_msg(abc, 3, 1'b0, 1'b1,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, "abc_post_rst");
    reset_abort(abc, 3, 72, "rst_out");
    run_msg(abc, 3, 1'b0, 1'b1,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, "abc_post_rst2");

    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run_msg(msg, 60, 1'b1, 1'b0, '0, "len60");

    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run_msg(msg, 55, 1'b0, 1'b0, '0, "len55");

    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(0, 55);
      for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
      run_msg(msg, len, 1'b1, 1'b0, '0, $sformatf("rand%0d_len%0d", r, len));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
